// File: rtl/bin_thresh_ctrl_pkg.sv
// Shared definitions for the binarization threshold controller: mode codes,
// FSM state type, default parameters and the saturating manual-step helper.
package bin_thresh_ctrl_pkg;

    localparam logic [1:0] MODE_FIXED  = 2'd0;
    localparam logic [1:0] MODE_MANUAL = 2'd1;
    localparam logic [1:0] MODE_AUTO   = 2'd2;

    localparam logic [7:0] DEF_THRESH_DFLT = 8'd90;
    localparam logic [7:0] STEP_DFLT       = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    // Simultaneous up and down presses cancel out.
    function automatic logic [7:0] adjust_thresh(input logic [7:0] cur,
                                                 input logic [7:0] step,
                                                 input logic       up,
                                                 input logic       dn);
        logic [7:0] res;
        res = cur;
        if (up && !dn) begin
            res = (cur > (8'd255 - step)) ? 8'd255 : cur + step;
        end else if (dn && !up) begin
            res = (cur < step) ? 8'd0 : cur - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_div8.sv
// Restoring divider producing an 8-bit quotient MSB first, one bit per cycle.
// The quotient must fit in 8 bits (dividend <= 255 * divisor).
module seq_div8 #(
    parameter int SUM_W = 28,
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [SUM_W-1:0] dividend_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic [7:0]       quot_o,
    output logic             done_o
);

    logic [SUM_W-1:0] rem_q,  rem_d;
    logic [SUM_W-1:0] dsh_q,  dsh_d;
    logic [7:0]       quot_q, quot_d;
    logic [2:0]       iter_q, iter_d;
    logic             run_q,  run_d;
    logic             ge;

    assign ge = (rem_q >= dsh_q);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rem_d  = rem_q;
        dsh_d  = dsh_q;
        quot_d = quot_q;
        iter_d = iter_q;
        run_d  = run_q;
        if (start_i) begin
            // Divisor pre-shifted to the weight of quotient bit 7.
            rem_d  = dividend_i;
            dsh_d  = SUM_W'(divisor_i) << 7;
            quot_d = '0;
            iter_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (ge) begin
                rem_d = rem_q - dsh_q;
            end
            quot_d = {quot_q[6:0], ge};
            dsh_d  = dsh_q >> 1;
            iter_d = iter_q + 3'd1;
            if (iter_q == 3'd7) begin
                run_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dsh_q  <= '0;
            quot_q <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dsh_q  <= dsh_d;
            quot_q <= quot_d;
            iter_q <= iter_d;
            run_q  <= run_d;
        end
    end

    // Done flags the cycle in which the last bit is being resolved.
    assign done_o = run_q && (iter_q == 3'd7);
    assign quot_o = quot_q;

endmodule

// File: rtl/bin_thresh_ctrl.sv
// Binarization threshold controller: fixed, manual (key-adjusted) or per-frame
// mean-luma threshold, applied only at frame boundaries.
module bin_thresh_ctrl
    import bin_thresh_ctrl_pkg::*;
#(
    parameter logic [7:0] DEF_THRESH = DEF_THRESH_DFLT,
    parameter logic [7:0] STEP       = STEP_DFLT,
    parameter int         SUM_W      = 28,
    parameter int         CNT_W      = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_de,
    input  logic [7:0] color,
    input  logic [1:0] mode,
    input  logic       key_up,
    input  logic       key_dn,
    output logic [7:0] threshold,
    output logic       thresh_valid,
    output logic       busy
);

    state_t           state_q, state_d;
    logic             vs_q;
    logic             vs_rise;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_sat;
    logic [1:0]       mode_l_q, mode_l_d;
    logic             cnt_zero_q, cnt_zero_d;
    logic [7:0]       manual_q, manual_d;
    logic [7:0]       thresh_q, thresh_d;
    logic             valid_q, valid_d;
    logic             div_start;
    logic             div_done;
    logic [7:0]       div_quot;

    assign vs_rise = pre_frame_vsync & ~vs_q;
    assign cnt_sat = &cnt_q;

    // Once the pixel count saturates the sum freezes too, keeping sum <= 255*cnt.
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (vs_rise) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (pre_frame_de && !cnt_sat) begin
            sum_d = sum_q + SUM_W'(color);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign manual_d = adjust_thresh(manual_q, STEP, key_up, key_dn);

    always_comb begin
        state_d    = state_q;
        mode_l_d   = mode_l_q;
        cnt_zero_d = cnt_zero_q;
        thresh_d   = thresh_q;
        valid_d    = 1'b0;
        div_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vs_rise) begin
                    mode_l_d   = mode;
                    cnt_zero_d = (cnt_q == '0);
                    if ((mode == MODE_AUTO) && (cnt_q != '0)) begin
                        div_start = 1'b1;
                        state_d   = ST_DIV;
                    end else begin
                        state_d = ST_UPDATE;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
                case (mode_l_q)
                    MODE_MANUAL: thresh_d = manual_q;
                    MODE_AUTO:   if (!cnt_zero_q) thresh_d = div_quot;
                    default:     thresh_d = DEF_THRESH;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vs_q       <= 1'b0;
            sum_q      <= '0;
            cnt_q      <= '0;
            mode_l_q   <= MODE_FIXED;
            cnt_zero_q <= 1'b0;
            manual_q   <= DEF_THRESH;
            thresh_q   <= DEF_THRESH;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= pre_frame_vsync;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            mode_l_q   <= mode_l_d;
            cnt_zero_q <= cnt_zero_d;
            manual_q   <= manual_d;
            thresh_q   <= thresh_d;
            valid_q    <= valid_d;
        end
    end

    seq_div8 #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (sum_q),
        .divisor_i  (cnt_q),
        .quot_o     (div_quot),
        .done_o     (div_done)
    );

    assign threshold    = thresh_q;
    assign thresh_valid = valid_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bin_thresh_ctrl.sv
// Directed self-checking bench for bin_thresh_ctrl, with a narrow-counter
// second instance used to reach count saturation quickly.
module tb_bin_thresh_ctrl;

    logic       clk;
    logic       rst_n;
    logic       pre_frame_vsync;
    logic       pre_frame_de;
    logic [7:0] color;
    logic [1:0] mode;
    logic       key_up;
    logic       key_dn;
    logic [7:0] threshold;
    logic       thresh_valid;
    logic       busy;
    logic [7:0] s_threshold;
    logic       s_thresh_valid;
    logic       s_busy;

    int checks;
    int failures;

    bin_thresh_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pre_frame_vsync (pre_frame_vsync),
        .pre_frame_de    (pre_frame_de),
        .color           (color),
        .mode            (mode),
        .key_up          (key_up),
        .key_dn          (key_dn),
        .threshold       (threshold),
        .thresh_valid    (thresh_valid),
        .busy            (busy)
    );

    bin_thresh_ctrl #(
        .SUM_W (14),
        .CNT_W (6)
    ) dut_small (
        .clk             (clk),
        .rst_n           (rst_n),
        .pre_frame_vsync (pre_frame_vsync),
        .pre_frame_de    (pre_frame_de),
        .color           (color),
        .mode            (mode),
        .key_up          (key_up),
        .key_dn          (key_dn),
        .threshold       (s_threshold),
        .thresh_valid    (s_thresh_valid),
        .busy            (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] px);
        pre_frame_de = 1'b1;
        color        = px;
        step();
        pre_frame_de = 1'b0;
    endtask

    task automatic press(input logic up, input logic dn);
        key_up = up;
        key_dn = dn;
        step();
        key_up = 1'b0;
        key_dn = 1'b0;
    endtask

    // Raise vsync in cycle E and check the result appears exactly at E+lat.
    task automatic frame_edge(input int lat, input logic [7:0] exp, input string tag);
        pre_frame_vsync = 1'b1;
        step();
        pre_frame_vsync = 1'b0;
        pre_frame_de    = 1'b0;
        color           = 8'd0;
        repeat (lat - 2) step();
        check({tag, "_early_valid"}, thresh_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
        step();
        check({tag, "_thr"}, threshold, exp);
        check({tag, "_valid"}, thresh_valid, 1'b1);
        step();
        check({tag, "_valid_1cyc"}, thresh_valid, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        pre_frame_vsync = 1'b0;
        pre_frame_de    = 1'b0;
        color           = 8'd0;
        mode            = 2'd0;
        key_up          = 1'b0;
        key_dn          = 1'b0;
        step();
        step();
        check("rst_thr", threshold, 8'd90);
        check("rst_valid", thresh_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (4) step();
        check("post_rst_no_update", thresh_valid, 1'b0);
        check("post_rst_idle", busy, 1'b0);

        // Auto mean of {10,20,30,40} = 25; the de pixel in cycle E is dropped.
        mode = 2'd2;
        feed(8'd10);
        feed(8'd20);
        feed(8'd30);
        feed(8'd40);
        pre_frame_de = 1'b1;
        color        = 8'd255;
        frame_edge(10, 8'd25, "auto");

        // Manual: 90 + 3*4 = 102, only visible after an update.
        mode = 2'd1;
        repeat (3) press(1'b1, 1'b0);
        step();
        check("manual_not_direct", threshold, 8'd25);
        frame_edge(2, 8'd102, "man_up");
        repeat (30) press(1'b0, 1'b1);
        frame_edge(2, 8'd0, "man_dn_sat");
        press(1'b1, 1'b1);
        frame_edge(2, 8'd0, "man_both");
        press(1'b1, 1'b0);
        frame_edge(2, 8'd4, "man_one_up");

        mode = 2'd0;
        frame_edge(2, 8'd90, "fixed");
        mode = 2'd1;
        frame_edge(2, 8'd4, "man_again");
        mode = 2'd3;
        frame_edge(2, 8'd90, "mode3");

        // Mean of {50,51} floors to 50; an empty auto frame then holds it.
        mode = 2'd2;
        feed(8'd50);
        feed(8'd51);
        frame_edge(10, 8'd50, "auto_floor");
        frame_edge(2, 8'd50, "empty");

        // Second edge at E+4 clears the pixels fed in E+1..E+3 without restarting.
        feed(8'd100);
        feed(8'd200);
        feed(8'd0);
        pre_frame_vsync = 1'b1;
        step();
        pre_frame_vsync = 1'b0;
        pre_frame_de    = 1'b1;
        color           = 8'd250;
        step();
        step();
        step();
        pre_frame_de    = 1'b0;
        pre_frame_vsync = 1'b1;
        step();
        pre_frame_vsync = 1'b0;
        repeat (4) step();
        check("div_edge_early", thresh_valid, 1'b0);
        step();
        check("div_edge_thr", threshold, 8'd100);
        check("div_edge_valid", thresh_valid, 1'b1);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (thresh_valid) pulses++;
        end
        check("div_edge_no_second", pulses, 0);
        feed(8'd60);
        feed(8'd61);
        frame_edge(10, 8'd60, "acc_cleared");

        // Reset at E+5 abandons the divide.
        feed(8'd200);
        pre_frame_vsync = 1'b1;
        step();
        pre_frame_vsync = 1'b0;
        repeat (4) step();
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_thr", threshold, 8'd90);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", thresh_valid, 1'b0);
        step();
        step();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (thresh_valid) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        check("midrst_thr_hold", threshold, 8'd90);
        mode = 2'd1;
        frame_edge(2, 8'd90, "manual_reset_val");

        // Full scale: the narrow instance saturates its count at 63 pixels.
        mode = 2'd2;
        repeat (100) feed(8'd255);
        frame_edge(10, 8'd255, "fullscale");
        check("fullscale_small_thr", s_threshold, 8'd255);
        check("fullscale_small_idle", s_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
